bc_datapath_io: RTL and testbench
=================================

# bc_datapath_io

Parametrised second-generation Basic Computer datapath: common bus, AR/PC/DR/AC/IR/TR registers, E flip-flop, ALU, status flags and an external memory port. It adds flag-handshaked input/output channels (INPR/FGI, OUTR/FGO) and interrupt state (IEN, R). It sits between the control unit, which drives `ctrl`, `bus_sel` and `alu_op`, and a synchronous-write/combinational-read memory.

## Interface
- `DATA_W`, 16, word width (bus, DR, AC, IR, TR).
- `ADDR_W`, 12, AR/PC width; must be less than `DATA_W`.
- `IO_W`, 8, INPR/OUTR width; must be at most `DATA_W`.
- `clk` input 1, clock.
- `RST_N` input 1, synchronous active-low reset. One clock; all state is sampled on the rising edge.
- `ctrl` input 25, one-hot-capable control micro-ops (bit map in Operation).
- `bus_sel` input 3, bus source: 0 `ext_wrd`, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 `mem_rdata`.
- `alu_op` input 3, ALU operation.
- `ext_wrd` input DATA_W, external word for program loading.
- `mem_addr` output ADDR_W, equals AR.
- `mem_wdata` output DATA_W, equals bus.
- `mem_we` output 1, equals ctrl MEM_WE.
- `mem_rdata` input DATA_W, combinational read data.
- `in_valid`/`in_data` input 1/IO_W, input channel.
- `in_ready` output 1, equals ~FGI.
- `out_valid`/`out_data` output 1/IO_W, equal ~FGO and OUTR.
- `out_ready` input 1, output channel.
- `pc_out`, `ar_out`, `ir_out`, `ac_out`, `dr_out`, `tr_out` output, register taps.
- `e_out`, `ien_out`, `r_out` output 1, flag taps.
- `co`, `z`, `n`, `ovf` output 1, registered status flags.
- `irq` output 1, IEN & (FGI | FGO).

## Operation
- ctrl bits:
  - 0–2: LD/INR/CLR_AR
  - 3–5: LD/INR/CLR_PC
  - 6–8: LD/INR/CLR_DR
  - 9–11: LD/INR/CLR_AC
  - 12: LD_IR
  - 13–15: LD/INR/CLR_TR
  - 16: MEM_WE
  - 17: CLR_E
  - 18: CMP_E
  - 19: LD_OUTR
  - 20: CLR_FGI
  - 21/22: SET/CLR_IEN
  - 23/24: SET/CLR_R
- Per-register priority: CLR > LD > INR. INR wraps modulo 2^width.
- AR and PC load from `bus[ADDR_W-1:0]`; AR/PC drive the bus zero-extended.
- AC loads the ALU result; DR, IR and TR load the bus.
- `alu_op` codes:
  - 0: AND, AC&DR
  - 1: ADD, AC+DR
  - 2: LDA, DR
  - 3: CMA, ~AC
  - 4: CIR, {E, AC[MSB:1]}
  - 5: CIL, {AC[MSB-1:0], E}
  - 6: INP, AC with low IO_W bits replaced by INPR
  - 7: PASS, AC
- On LD_AC, the ALU also writes E:
  - ADD: E gets the carry.
  - CIR: E gets AC[0].
  - CIL: E gets AC[MSB].
  - Other ops: E unchanged.
- E priority: CLR_E > CMP_E > ALU write.
- Status flags update only on an effective LD_AC:
  - z: result==0.
  - n: result[MSB].
  - co: ADD carry, otherwise 0.
  - ovf: ADD signed overflow, otherwise 0.
- Input channel:
  - Accept when in_valid & ~FGI: INPR <= in_data, FGI <= 1.
  - CLR_FGI clears FGI. No accept is possible in the same cycle because in_ready was 0.
- Output channel:
  - LD_OUTR: OUTR <= AC[IO_W-1:0], FGO <= 0.
  - Handshake when out_valid & out_ready: FGO <= 1.
  - Simultaneous LD_OUTR and handshake: the consumer takes the old OUTR, OUTR takes the new value, FGO stays 0.
- IEN and R: SET and CLR in the same cycle resolves to CLR.

## Timing
- Every register, flag and channel update takes effect on the edge following its ctrl assertion. The bus and the memory port are combinational.
- A memory read is the same cycle via bus_sel=7. A memory write commits at the edge with MEM_WE.
- Reset values, same-edge: all registers 0, INPR/OUTR 0, E/IEN/R 0, flags 0, FGI 0, FGO 1.
  - Resulting outputs: in_ready=1, out_valid=0, irq=0.
- Reset asserted mid-transfer discards a pending INPR/OUTR value.
- Reset dominates every ctrl bit and handshake.

## Structure
- Package `bc_pkg`: ctrl bit-index localparams, bus_sel codes, alu_op enum.
- Sub-module `bc_alu`: combinational, parametrised by DATA_W/IO_W. Outputs the result, e_next, e_we, co and ovf.
- The register with CLR/LD/INR is inferred inline.

## Test plan
- Reset: release RST_N, then check all taps are 0, FGO=1, in_ready=1, out_valid=0.
- ADD overflow: AC=0x7FFF, DR=0x0001, LD_AC with ADD, then check AC=0x8000, ovf=1, n=1, co=0, E=0. Next, AC=0xFFFF + DR=0x0001, then check AC=0, z=1, co=1, E=1.
- Priority: assert CLR_PC+LD_PC+INR_PC with bus=0x123, then check PC=0. Assert LD_PC+INR_PC, then check PC=0x123. With PC=0xFFF, INR_PC gives 0x000.
- Input channel: in_valid with 0xA5, then check FGI=1, in_ready=0, irq=1 with IEN set. INP gives AC low byte 0xA5. CLR_FGI restores in_ready the next cycle.
- Output channel: AC=0x1234, LD_OUTR, then check out_data=0x34, out_valid=1. Hold out_ready=1 together with LD_OUTR of 0x56: the first beat delivers 0x34, out_valid stays 1 with 0x56.
- Rotates: AC=0x8001, E=0, CIL gives AC=0x0002, E=1. Then CIR gives AC=0x8001, E=0.

Source files
------------

// File: rtl/bc_pkg.sv
// Shared constants for the Basic Computer datapath: ctrl bit map, bus source
// codes and ALU operation encoding.
package bc_pkg;

  localparam int CTRL_W = 25;

  // ctrl micro-op bit indices
  localparam int C_LD_AR   = 0;
  localparam int C_INR_AR  = 1;
  localparam int C_CLR_AR  = 2;
  localparam int C_LD_PC   = 3;
  localparam int C_INR_PC  = 4;
  localparam int C_CLR_PC  = 5;
  localparam int C_LD_DR   = 6;
  localparam int C_INR_DR  = 7;
  localparam int C_CLR_DR  = 8;
  localparam int C_LD_AC   = 9;
  localparam int C_INR_AC  = 10;
  localparam int C_CLR_AC  = 11;
  localparam int C_LD_IR   = 12;
  localparam int C_LD_TR   = 13;
  localparam int C_INR_TR  = 14;
  localparam int C_CLR_TR  = 15;
  localparam int C_MEM_WE  = 16;
  localparam int C_CLR_E   = 17;
  localparam int C_CMP_E   = 18;
  localparam int C_LD_OUTR = 19;
  localparam int C_CLR_FGI = 20;
  localparam int C_SET_IEN = 21;
  localparam int C_CLR_IEN = 22;
  localparam int C_SET_R   = 23;
  localparam int C_CLR_R   = 24;

  // bus source selects
  localparam logic [2:0] BUS_EXT = 3'd0;
  localparam logic [2:0] BUS_AR  = 3'd1;
  localparam logic [2:0] BUS_PC  = 3'd2;
  localparam logic [2:0] BUS_DR  = 3'd3;
  localparam logic [2:0] BUS_AC  = 3'd4;
  localparam logic [2:0] BUS_IR  = 3'd5;
  localparam logic [2:0] BUS_TR  = 3'd6;
  localparam logic [2:0] BUS_MEM = 3'd7;

  typedef enum logic [2:0] {
    ALU_AND  = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_LDA  = 3'd2,
    ALU_CMA  = 3'd3,
    ALU_CIR  = 3'd4,
    ALU_CIL  = 3'd5,
    ALU_INP  = 3'd6,
    ALU_PASS = 3'd7
  } alu_op_e;

endpackage

// File: rtl/bc_alu.sv
// Combinational accumulator ALU. Produces the AC result, the E value it would
// write (with a write enable), and carry / signed overflow for ADD.
module bc_alu
  import bc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IO_W   = 8
) (
  input  logic [DATA_W-1:0] ac,
  input  logic [DATA_W-1:0] dr,
  input  logic [IO_W-1:0]   inpr,
  input  logic              e,
  input  alu_op_e           op,
  output logic [DATA_W-1:0] res,
  output logic              e_next,
  output logic              e_we,
  output logic              co,
  output logic              ovf
);

  logic [DATA_W:0] sum;

  // result and side outputs; anything not touched by an op keeps AC / E
  always_comb begin
    sum    = {1'b0, ac} + {1'b0, dr};
    res    = ac;
    e_next = e;
    e_we   = 1'b0;
    co     = 1'b0;
    ovf    = 1'b0;
    unique case (op)
      ALU_AND: res = ac & dr;
      ALU_ADD: begin
        res    = sum[DATA_W-1:0];
        e_next = sum[DATA_W];
        e_we   = 1'b1;
        co     = sum[DATA_W];
        // same-sign operands yielding an opposite-sign result
        ovf    = (ac[DATA_W-1] == dr[DATA_W-1]) && (sum[DATA_W-1] != ac[DATA_W-1]);
      end
      ALU_LDA: res = dr;
      ALU_CMA: res = ~ac;
      ALU_CIR: begin
        res    = {e, ac[DATA_W-1:1]};
        e_next = ac[0];
        e_we   = 1'b1;
      end
      ALU_CIL: begin
        res    = {ac[DATA_W-2:0], e};
        e_next = ac[DATA_W-1];
        e_we   = 1'b1;
      end
      ALU_INP: res[IO_W-1:0] = inpr;
      ALU_PASS: res = ac;
      default: res = ac;
    endcase
  end

endmodule

// File: rtl/bc_datapath_io.sv
// Basic Computer datapath with common bus, register file, E flip-flop, status
// flags, memory port, flag-handshaked I/O channels and interrupt state.
module bc_datapath_io
  import bc_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12,
  parameter int IO_W   = 8
) (
  input  logic              clk,
  input  logic              RST_N,
  input  logic [CTRL_W-1:0] ctrl,
  input  logic [2:0]        bus_sel,
  input  logic [2:0]        alu_op,
  input  logic [DATA_W-1:0] ext_wrd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              in_valid,
  input  logic [IO_W-1:0]   in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [IO_W-1:0]   out_data,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] ar_out,
  output logic [DATA_W-1:0] ir_out,
  output logic [DATA_W-1:0] ac_out,
  output logic [DATA_W-1:0] dr_out,
  output logic [DATA_W-1:0] tr_out,
  output logic              e_out,
  output logic              ien_out,
  output logic              r_out,
  output logic              co,
  output logic              z,
  output logic              n,
  output logic              ovf,
  output logic              irq
);

  logic [ADDR_W-1:0] ar_q, ar_d, pc_q, pc_d;
  logic [DATA_W-1:0] dr_q, dr_d, ac_q, ac_d, ir_q, ir_d, tr_q, tr_d;
  logic [IO_W-1:0]   inpr_q, inpr_d, outr_q, outr_d;
  logic e_q, e_d, co_q, co_d, z_q, z_d, n_q, n_d, ovf_q, ovf_d;
  logic fgi_q, fgi_d, fgo_q, fgo_d, ien_q, ien_d, r_q, r_d;

  logic [DATA_W-1:0] bus, alu_res;
  logic alu_e_next, alu_e_we, alu_co, alu_ovf;
  logic ld_ac_eff, in_acc, out_hs;

  // common bus source mux; AR/PC are zero-extended
  always_comb begin
    bus = '0;
    unique case (bus_sel)
      BUS_EXT: bus = ext_wrd;
      BUS_AR:  bus = {{(DATA_W-ADDR_W){1'b0}}, ar_q};
      BUS_PC:  bus = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
      BUS_DR:  bus = dr_q;
      BUS_AC:  bus = ac_q;
      BUS_IR:  bus = ir_q;
      BUS_TR:  bus = tr_q;
      BUS_MEM: bus = mem_rdata;
      default: bus = '0;
    endcase
  end

  bc_alu #(.DATA_W(DATA_W), .IO_W(IO_W)) u_alu (
    .ac     (ac_q),
    .dr     (dr_q),
    .inpr   (inpr_q),
    .e      (e_q),
    .op     (alu_op_e'(alu_op)),
    .res    (alu_res),
    .e_next (alu_e_next),
    .e_we   (alu_e_we),
    .co     (alu_co),
    .ovf    (alu_ovf)
  );

  // next-state for every register: CLR beats LD beats INR
  always_comb begin
    // a LD_AC shadowed by CLR_AC does not count as an ALU write
    ld_ac_eff = ctrl[C_LD_AC] & ~ctrl[C_CLR_AC];
    in_acc    = in_valid & ~fgi_q;
    out_hs    = ~fgo_q & out_ready;

    ar_d = ar_q;
    if      (ctrl[C_CLR_AR]) ar_d = '0;
    else if (ctrl[C_LD_AR])  ar_d = bus[ADDR_W-1:0];
    else if (ctrl[C_INR_AR]) ar_d = ar_q + ADDR_W'(1);

    pc_d = pc_q;
    if      (ctrl[C_CLR_PC]) pc_d = '0;
    else if (ctrl[C_LD_PC])  pc_d = bus[ADDR_W-1:0];
    else if (ctrl[C_INR_PC]) pc_d = pc_q + ADDR_W'(1);

    dr_d = dr_q;
    if      (ctrl[C_CLR_DR]) dr_d = '0;
    else if (ctrl[C_LD_DR])  dr_d = bus;
    else if (ctrl[C_INR_DR]) dr_d = dr_q + DATA_W'(1);

    ac_d = ac_q;
    if      (ctrl[C_CLR_AC]) ac_d = '0;
    else if (ctrl[C_LD_AC])  ac_d = alu_res;
    else if (ctrl[C_INR_AC]) ac_d = ac_q + DATA_W'(1);

    ir_d = ctrl[C_LD_IR] ? bus : ir_q;

    tr_d = tr_q;
    if      (ctrl[C_CLR_TR]) tr_d = '0;
    else if (ctrl[C_LD_TR])  tr_d = bus;
    else if (ctrl[C_INR_TR]) tr_d = tr_q + DATA_W'(1);

    e_d = e_q;
    if      (ctrl[C_CLR_E])          e_d = 1'b0;
    else if (ctrl[C_CMP_E])          e_d = ~e_q;
    else if (ld_ac_eff && alu_e_we)  e_d = alu_e_next;

    co_d  = co_q;
    z_d   = z_q;
    n_d   = n_q;
    ovf_d = ovf_q;
    if (ld_ac_eff) begin
      co_d  = alu_co;
      z_d   = (alu_res == '0);
      n_d   = alu_res[DATA_W-1];
      ovf_d = alu_ovf;
    end

    // input channel: FGI set on accept, cleared by control
    inpr_d = in_acc ? in_data : inpr_q;
    fgi_d  = fgi_q;
    if      (ctrl[C_CLR_FGI]) fgi_d = 1'b0;
    else if (in_acc)          fgi_d = 1'b1;

    // output channel: a new load keeps the channel busy even if the old
    // value is taken on the same edge
    outr_d = outr_q;
    fgo_d  = fgo_q;
    if (ctrl[C_LD_OUTR]) begin
      outr_d = ac_q[IO_W-1:0];
      fgo_d  = 1'b0;
    end else if (out_hs) begin
      fgo_d  = 1'b1;
    end

    ien_d = ien_q;
    if      (ctrl[C_CLR_IEN]) ien_d = 1'b0;
    else if (ctrl[C_SET_IEN]) ien_d = 1'b1;

    r_d = r_q;
    if      (ctrl[C_CLR_R]) r_d = 1'b0;
    else if (ctrl[C_SET_R]) r_d = 1'b1;
  end

  // state register with synchronous reset; FGO resets to 1 (output empty)
  always_ff @(posedge clk) begin
    if (!RST_N) begin
      ar_q <= '0; pc_q <= '0; dr_q <= '0; ac_q <= '0; ir_q <= '0; tr_q <= '0;
      inpr_q <= '0; outr_q <= '0;
      e_q <= 1'b0; co_q <= 1'b0; z_q <= 1'b0; n_q <= 1'b0; ovf_q <= 1'b0;
      fgi_q <= 1'b0; fgo_q <= 1'b1; ien_q <= 1'b0; r_q <= 1'b0;
    end else begin
      ar_q <= ar_d; pc_q <= pc_d; dr_q <= dr_d; ac_q <= ac_d; ir_q <= ir_d; tr_q <= tr_d;
      inpr_q <= inpr_d; outr_q <= outr_d;
      e_q <= e_d; co_q <= co_d; z_q <= z_d; n_q <= n_d; ovf_q <= ovf_d;
      fgi_q <= fgi_d; fgo_q <= fgo_d; ien_q <= ien_d; r_q <= r_d;
    end
  end

  assign mem_addr  = ar_q;
  assign mem_wdata = bus;
  assign mem_we    = ctrl[C_MEM_WE];
  assign in_ready  = ~fgi_q;
  assign out_valid = ~fgo_q;
  assign out_data  = outr_q;
  assign pc_out    = pc_q;
  assign ar_out    = ar_q;
  assign ir_out    = ir_q;
  assign ac_out    = ac_q;
  assign dr_out    = dr_q;
  assign tr_out    = tr_q;
  assign e_out     = e_q;
  assign ien_out   = ien_q;
  assign r_out     = r_q;
  assign co        = co_q;
  assign z         = z_q;
  assign n         = n_q;
  assign ovf       = ovf_q;
  assign irq       = ien_q & (fgi_q | fgo_q);

endmodule

// File: tb/tb_bc_datapath_io.sv
// Directed bench for bc_datapath_io with a small synchronous-write memory model.
module tb_bc_datapath_io;
  import bc_pkg::*;

  logic              clk = 1'b0;
  logic              RST_N;
  logic [CTRL_W-1:0] ctrl;
  logic [2:0]        bus_sel, alu_op;
  logic [15:0]       ext_wrd, mem_wdata, mem_rdata;
  logic [11:0]       mem_addr, pc_out, ar_out;
  logic              mem_we, in_valid, in_ready, out_valid, out_ready;
  logic [7:0]        in_data, out_data;
  logic [15:0]       ir_out, ac_out, dr_out, tr_out;
  logic              e_out, ien_out, r_out, co, z, n, ovf, irq;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem [0:4095];

  bc_datapath_io dut (
    .clk(clk), .RST_N(RST_N), .ctrl(ctrl), .bus_sel(bus_sel), .alu_op(alu_op),
    .ext_wrd(ext_wrd), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .pc_out(pc_out), .ar_out(ar_out), .ir_out(ir_out), .ac_out(ac_out),
    .dr_out(dr_out), .tr_out(tr_out), .e_out(e_out), .ien_out(ien_out), .r_out(r_out),
    .co(co), .z(z), .n(n), .ovf(ovf), .irq(irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  function automatic logic [CTRL_W-1:0] b(input int i);
    return CTRL_W'(1) << i;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // apply one cycle of control, then sample 1ns after the edge
  task automatic step(input logic [CTRL_W-1:0] c, input logic [2:0] bs, input logic [2:0] op);
    ctrl = c; bus_sel = bs; alu_op = op;
    @(posedge clk); #1;
    ctrl = '0;
  endtask

  task automatic load_ac(input logic [15:0] v);
    ext_wrd = v;
    step(b(C_LD_DR), BUS_EXT, ALU_AND);
    step(b(C_LD_AC), BUS_EXT, ALU_LDA);
  endtask

  task automatic load_dr(input logic [15:0] v);
    ext_wrd = v;
    step(b(C_LD_DR), BUS_EXT, ALU_AND);
  endtask

  initial begin
    RST_N = 1'b0; ctrl = '0; bus_sel = '0; alu_op = '0; ext_wrd = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 RST_N = 1'b1;
    @(posedge clk); #1;

    // reset state
    chk("rst_taps", {pc_out, ar_out, ir_out, ac_out, dr_out, tr_out} == '0, 1'b1);
    chk("rst_flags", {e_out, ien_out, r_out, co, z, n, ovf}, 7'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_out_data", out_data, 8'h00);

    // ADD signed overflow
    load_ac(16'h7FFF);
    load_dr(16'h0001);
    step(b(C_LD_AC), BUS_EXT, ALU_ADD);
    chk("add_ovf_ac", ac_out, 16'h8000);
    chk("add_ovf_flags", {ovf, n, co, e_out, z}, 5'b11000);

    // ADD carry out to zero
    load_ac(16'hFFFF);
    load_dr(16'h0001);
    step(b(C_LD_AC), BUS_EXT, ALU_ADD);
    chk("add_carry_ac", ac_out, 16'h0000);
    chk("add_carry_flags", {ovf, n, co, e_out, z}, 5'b00111);

    // PC priority and wrap
    ext_wrd = 16'h0123;
    step(b(C_CLR_PC) | b(C_LD_PC) | b(C_INR_PC), BUS_EXT, ALU_AND);
    chk("pc_clr_prio", pc_out, 12'h000);
    step(b(C_LD_PC) | b(C_INR_PC), BUS_EXT, ALU_AND);
    chk("pc_ld_prio", pc_out, 12'h123);
    ext_wrd = 16'h0FFF;
    step(b(C_LD_PC), BUS_EXT, ALU_AND);
    step(b(C_INR_PC), BUS_EXT, ALU_AND);
    chk("pc_wrap", pc_out, 12'h000);

    // AR truncates on load, drives bus zero-extended
    ext_wrd = 16'hABCD;
    step(b(C_LD_AR), BUS_EXT, ALU_AND);
    chk("ar_trunc", ar_out, 12'hBCD);
    step(b(C_LD_DR), BUS_AR, ALU_AND);
    chk("ar_zext", dr_out, 16'h0BCD);

    // output channel load, then input channel with interrupt
    load_ac(16'h1234);
    step(b(C_LD_OUTR), BUS_EXT, ALU_AND);
    chk("outr_data", out_data, 8'h34);
    chk("outr_valid", out_valid, 1'b1);
    step(b(C_SET_IEN), BUS_EXT, ALU_AND);
    chk("ien_set", ien_out, 1'b1);
    chk("irq_idle", irq, 1'b0);
    in_valid = 1'b1; in_data = 8'hA5;
    step('0, BUS_EXT, ALU_AND);
    chk("in_ready_busy", in_ready, 1'b0);
    chk("irq_in", irq, 1'b1);
    in_data = 8'h5A;   // must be refused while FGI is set
    step('0, BUS_EXT, ALU_AND);
    in_valid = 1'b0;
    step(b(C_LD_AC), BUS_EXT, ALU_INP);
    chk("inp_ac", ac_out, 16'h12A5);
    step(b(C_CLR_FGI), BUS_EXT, ALU_AND);
    chk("clr_fgi_ready", in_ready, 1'b1);
    chk("clr_fgi_irq", irq, 1'b0);

    // simultaneous LD_OUTR and handshake
    load_ac(16'h0056);
    out_ready = 1'b1; ctrl = b(C_LD_OUTR); bus_sel = BUS_EXT; alu_op = ALU_AND;
    #1;
    chk("hs_old_data", out_data, 8'h34);
    chk("hs_old_valid", out_valid, 1'b1);
    @(posedge clk); #1;
    ctrl = '0;
    chk("hs_new_data", out_data, 8'h56);
    chk("hs_new_valid", out_valid, 1'b1);
    step('0, BUS_EXT, ALU_AND);
    out_ready = 1'b0;
    chk("hs_drained", out_valid, 1'b0);
    chk("irq_out", irq, 1'b1);
    step(b(C_SET_IEN) | b(C_CLR_IEN), BUS_EXT, ALU_AND);
    chk("ien_clr_prio", {ien_out, irq}, 2'b00);

    // memory write then read onto the bus
    ext_wrd = 16'h0010;
    step(b(C_LD_AR), BUS_EXT, ALU_AND);
    chk("mem_addr", mem_addr, 12'h010);
    ext_wrd = 16'hBEEF;
    step(b(C_MEM_WE), BUS_EXT, ALU_AND);
    step(b(C_LD_IR), BUS_MEM, ALU_AND);
    chk("mem_rd_ir", ir_out, 16'hBEEF);

    // rotates through E
    load_ac(16'h8001);
    step(b(C_CLR_E), BUS_EXT, ALU_AND);
    chk("clr_e", e_out, 1'b0);
    step(b(C_LD_AC), BUS_EXT, ALU_CIL);
    chk("cil", {ac_out, e_out}, {16'h0002, 1'b1});
    step(b(C_LD_AC), BUS_EXT, ALU_CIR);
    chk("cir", {ac_out, e_out}, {16'h8001, 1'b0});

    // CMA, AND, TR and misc bits
    step(b(C_LD_AC), BUS_EXT, ALU_CMA);
    chk("cma", {ac_out, n}, {16'h7FFE, 1'b0});
    step(b(C_LD_AC), BUS_EXT, ALU_AND);
    chk("and_zero", {ac_out, z}, {16'h0000, 1'b1});
    ext_wrd = 16'hFFFF;
    step(b(C_LD_TR), BUS_EXT, ALU_AND);
    step(b(C_INR_TR), BUS_EXT, ALU_AND);
    chk("tr_wrap", tr_out, 16'h0000);
    step(b(C_CMP_E), BUS_EXT, ALU_AND);
    chk("cmp_e", e_out, 1'b1);
    step(b(C_SET_R), BUS_EXT, ALU_AND);
    chk("r_set", r_out, 1'b1);
    step(b(C_SET_R) | b(C_CLR_R), BUS_EXT, ALU_AND);
    chk("r_clr_prio", r_out, 1'b0);

    // reset in the middle of pending transfers
    load_ac(16'h00C3);
    in_valid = 1'b1; in_data = 8'h77;
    step(b(C_LD_OUTR), BUS_EXT, ALU_AND);
    in_valid = 1'b0;
    chk("pre_rst_busy", {in_ready, out_valid}, 2'b01);
    RST_N = 1'b0;
    step(b(C_LD_AC) | b(C_SET_IEN), BUS_EXT, ALU_PASS);
    RST_N = 1'b1;
    chk("mid_rst_io", {in_ready, out_valid, out_data}, {1'b1, 1'b0, 8'h00});
    chk("mid_rst_ac", {ac_out, ien_out}, {16'h0000, 1'b0});
    step(b(C_LD_AC), BUS_EXT, ALU_INP);
    chk("mid_rst_inpr", ac_out, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // hard stop if the sequence ever stalls
  initial begin
    #100000;
    $display("FAIL timeout: sequence did not complete");
    $fatal(1, "timeout");
  end

endmodule
